// File: rtl/muldiv_seq_ctrl.sv
// Sequential unsigned multiply/divide: shift-add multiply and restoring shift-subtract
// divide, one bit per clock, time-sharing a single NBITS-wide carry-lookahead adder.

module carrylookahead #(
    parameter int NBITS = 6
) (
    input  logic [NBITS-1:0] x,
    input  logic [NBITS-1:0] y,
    input  logic             cin,
    output logic [NBITS-1:0] sum,
    output logic             cout
);
    logic [NBITS-1:0] p;
    logic [NBITS-1:0] g;
    logic [NBITS:0]   c;
    logic             term;

    assign p = x ^ y;
    assign g = x & y;

    // Each carry is the flat OR of generate terms propagated up to it, plus cin propagated.
    always_comb begin
        c    = '0;
        term = 1'b0;
        c[0] = cin;
        for (int i = 0; i < NBITS; i++) begin
            term = cin;
            for (int k = 0; k <= i; k++) term = term & p[k];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) term = term & p[k];
                c[i+1] = c[i+1] | term;
            end
        end
    end

    assign sum  = p ^ c[NBITS-1:0];
    assign cout = c[NBITS];
endmodule

module muldiv_seq_ctrl #(
    parameter int NBITS = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               op,
    input  logic [NBITS-1:0]   a,
    input  logic [NBITS-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*NBITS-1:0] product,
    output logic [NBITS-1:0]   quotient,
    output logic [NBITS-1:0]   remainder,
    output logic               div_by_zero,
    output logic [1:0]         dbg_state
);
    localparam int CW = $clog2(NBITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               op_q;
    logic [NBITS-1:0]   b_q;
    logic [CW-1:0]      cnt_q;
    // Shared working register: {P_hi, P_lo} for multiply, {R, Q} for divide.
    logic [2*NBITS-1:0] p_q;
    logic [2*NBITS-1:0] p_step;
    logic [NBITS-1:0]   trial;
    logic [NBITS-1:0]   add_x;
    logic [NBITS-1:0]   add_y;
    logic               add_cin;
    logic [NBITS-1:0]   add_sum;
    logic               add_cout;
    logic               accept;

    carrylookahead #(.NBITS(NBITS)) u_add (
        .x    (add_x),
        .y    (add_y),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign trial = {p_q[2*NBITS-2:NBITS], p_q[NBITS-1]};

    always_comb begin
        add_x   = p_q[2*NBITS-1:NBITS];
        add_y   = p_q[0] ? b_q : '0;
        add_cin = 1'b0;
        if (op_q) begin
            add_x   = trial;
            add_y   = ~b_q;
            add_cin = 1'b1;
        end
    end

    // A set R msb means the trial value exceeds NBITS bits, so it always covers the divisor.
    assign accept = p_q[2*NBITS-1] | add_cout;

    always_comb begin
        p_step = {add_cout, add_sum, p_q[NBITS-1:1]};
        if (op_q) begin
            if (accept) p_step = {add_sum, p_q[NBITS-2:0], 1'b1};
            else        p_step = {trial, p_q[NBITS-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (op && (b == '0)) ? DONE : CALC;
            CALC: if (cnt_q == '0) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= 1'b0;
            b_q         <= '0;
            cnt_q       <= '0;
            p_q         <= '0;
            product     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        b_q   <= b;
                        cnt_q <= CW'(NBITS - 1);
                        p_q   <= {{NBITS{1'b0}}, a};
                        if (op && (b == '0)) begin
                            quotient    <= '1;
                            remainder   <= a;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    p_q <= p_step;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else if (op_q) begin
                        quotient    <= p_step[NBITS-1:0];
                        remainder   <= p_step[2*NBITS-1:NBITS];
                        div_by_zero <= 1'b0;
                    end else begin
                        product <= p_step;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;
endmodule

// File: doc/muldiv_seq_ctrl.md
# muldiv_seq_ctrl

Sequential unsigned multiply/divide controller. It time-shares one NBITS-wide `carrylookahead` adder instance to compute a 2·NBITS product by shift-add, or an NBITS quotient and remainder by non-restoring-free (restoring) shift-subtract, one bit per clock. It sits between the operand source and the result consumer, using a start/done handshake, and replaces the combinational array multiplier and divider where area matters.

## Interface
- NBITS, 6: operand width; also the width of the internal adder instance; ≥2.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  1  0 = multiply, 1 = divide; sampled with start.
- a  in  NBITS  multiplicand / dividend (unsigned); sampled with start.
- b  in  NBITS  multiplier / divisor (unsigned); sampled with start.
- busy  out  1  high in CALC and DONE.
- done  out  1  one-cycle pulse, results valid.
- product  out  2·NBITS  multiply result.
- quotient  out  NBITS  divide quotient.
- remainder  out  NBITS  divide remainder.
- div_by_zero  out  1  last divide had b == 0.

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE; all outputs and internal registers are 0.
- IDLE: start=1 latches op, a, and b. The iteration counter loads NBITS-1. Next state is CALC, except when op=1 and b=0, where next state is DONE with the divide-by-zero flag set.
- CALC: performs one step per cycle. The counter decrements; when it reaches 0 and that step completes, next state is DONE.
- DONE: done=1 for exactly this cycle. The result outputs update on the edge entering DONE. Next state is IDLE unconditionally.
- start outside IDLE, including in DONE, is ignored with no queueing. op, a, and b changes after acceptance have no effect.
- Multiply (op=0): P is a 2·NBITS register, with P_hi=0 and P_lo=a at load.
  - Each step: if P[0]=1, the adder computes P_hi+b with cin=0, giving {cout,sum}; otherwise {cout,sum}={0,P_hi}.
  - P ← {cout, sum, P_lo} >> 1.
  - After NBITS steps, product=P. quotient, remainder, and div_by_zero are unchanged.
- Divide (op=1): R (NBITS bits) is 0 at load, and Q=a.
  - Each step: trial={R[NBITS-2:0], Q[NBITS-1]}. The adder computes trial + ~b with cin=1.
  - Accept if R[NBITS-1]=1 or cout=1. On accept, R ← sum and the new Q LSB is 1. On reject, R ← trial and the new Q LSB is 0. Q shifts left by one.
  - After NBITS steps, quotient=Q, remainder=R, div_by_zero=0. product is unchanged.
- Divide by zero: quotient=all ones, remainder=a, div_by_zero=1. No CALC cycles.
- Width rules:
  - All arithmetic is unsigned.
  - The adder cout is the only carry source.
  - No overflow is possible, since the product fits in 2·NBITS bits and the quotient fits in NBITS bits.
- Results hold until the next accepted operation reaches DONE.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No done pulse is produced, and the partial result is discarded.

## Timing
- Call the cycle in which start is sampled cycle 0.
- Normal multiply or divide: CALC occupies cycles 1..NBITS, and done=1 in cycle NBITS+1. busy is high in cycles 1..NBITS+1. The earliest next accepted start is in cycle NBITS+2.
- Divide by zero: done=1 and div_by_zero=1 in cycle 1; busy is high in cycle 1 only.
- Throughput is one operation per NBITS+2 cycles.
- Outputs are registered, with no combinational path from inputs to outputs. The adder lies on the single-cycle CALC path.

## Test plan
All cases use NBITS=6.
- Reset: rst pulse → busy=0, done=0, product=0, quotient=0, remainder=0, div_by_zero=0.
- Multiply corners:
  - a=63, b=63, op=0 → done in cycle 7, product=3969.
  - Then a=0, b=45 → product=0.
  - Then a=1, b=63 → product=63.
- Divide:
  - a=45, b=7, op=1 → done in cycle 7, quotient=6, remainder=3, div_by_zero=0.
  - a=5, b=9 → quotient=0, remainder=5.
  - a=63, b=1 → quotient=63, remainder=0.
- Divide by zero: a=37, b=0 → done in cycle 1, quotient=63, remainder=37, div_by_zero=1. A following valid divide clears div_by_zero.
- Busy protection: start with a=10, b=3, op=0, then pulse start with a=2, b=2, op=1 in cycles 3 and 7 → exactly one done, product=30, quotient and remainder unchanged.
- Mid-operation reset: rst asserted in cycle 4 of a multiply → outputs 0 immediately, no done. A new start after reset gives a correct result.
- Random regression: 10k random a, b, and op compared against a reference model (`*`, `/`, `%`), checking done latency and that exactly one done pulse occurs per accepted start.
